// File: rtl/count_down_timer.sv
// Loadable count-down timer with run/pause, abort and a clock-cycle prescaler.
// Define COUNT_DOWN_TIMER_AUTO_RELOAD_EN to restart from the loaded value when DONE sees run=1.
module count_down_timer #(
    parameter int WIDTH    = 9,
    parameter int TICK_DIV = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] start,
    input  logic             load,
    input  logic             run,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             done_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOADED, RUNNING, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [PW-1:0]    presc, presc_nxt;
    logic             pulse_nxt;
`ifdef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload, reload_nxt;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            count      <= '0;
            presc      <= '0;
            done_pulse <= 1'b0;
`ifdef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
            reload     <= '0;
`endif
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            presc      <= presc_nxt;
            done_pulse <= pulse_nxt;
`ifdef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
            reload     <= reload_nxt;
`endif
        end
    end

    // Priority is abort, then load (ignored while RUNNING), then run.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        presc_nxt = presc;
`ifdef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
        reload_nxt = reload;
`endif
        if (abort) begin
            state_nxt = IDLE;
            count_nxt = '0;
            presc_nxt = '0;
        end else if (load && (state != RUNNING)) begin
            state_nxt = LOADED;
            count_nxt = start;
            presc_nxt = '0;
`ifdef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
            reload_nxt = start;
`endif
        end else if (run) begin
            case (state)
                LOADED: begin
                    state_nxt = RUNNING;
                    presc_nxt = '0;
                end
                RUNNING: begin
                    if (count == '0) begin
                        state_nxt = DONE;
                    end else if (presc == PRESC_LAST) begin
                        presc_nxt = '0;
                        count_nxt = count - WIDTH'(1);
                        if (count == WIDTH'(1)) state_nxt = DONE;
                    end else begin
                        presc_nxt = presc + PW'(1);
                    end
                end
                DONE: begin
`ifdef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
                    state_nxt = RUNNING;
                    count_nxt = reload;
                    presc_nxt = '0;
`endif
                end
                default: ;
            endcase
        end
        pulse_nxt = (state_nxt == DONE) && (state != DONE);
    end

    assign busy = (state == RUNNING);
    assign done = (state == DONE);

endmodule

// File: tb/tb_count_down_timer.sv
// Bench for count_down_timer: TICK_DIV=1 and TICK_DIV=4 instances share stimulus and are
// checked every cycle against a run-cycle-counting model; honours COUNT_DOWN_TIMER_AUTO_RELOAD_EN.
module tb_count_down_timer;
    localparam int W = 9;
`ifdef COUNT_DOWN_TIMER_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int P_IDLE = 0, P_LOADED = 1, P_RUN = 2, P_DONE = 3;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] start = '0;
    logic         load = 1'b0, run = 1'b0, abort = 1'b0;
    logic [W-1:0] count1, count4;
    logic         busy1, busy4, done1, done4, dp1, dp4;

    count_down_timer #(.WIDTH(W), .TICK_DIV(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .start(start), .load(load), .run(run),
        .abort(abort), .count(count1), .busy(busy1), .done(done1), .done_pulse(dp1));

    count_down_timer #(.WIDTH(W), .TICK_DIV(4)) dut4 (
        .clock(clock), .reset_n(reset_n), .start(start), .load(load), .run(run),
        .abort(abort), .count(count4), .busy(busy4), .done(done4), .done_pulse(dp4));

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a run is described by its loaded value and the number of enabled cycles spent in it.
    int td[2]      = '{1, 4};
    int m_phase[2] = '{P_IDLE, P_IDLE};
    int m_base[2]  = '{0, 0};
    int m_rel[2]   = '{0, 0};
    int m_act[2]   = '{0, 0};
    int m_pulse[2] = '{0, 0};

    function automatic void m_reset(int k);
        m_phase[k] = P_IDLE; m_base[k] = 0; m_rel[k] = 0; m_act[k] = 0; m_pulse[k] = 0;
    endfunction

    function automatic void m_step(int k);
        m_pulse[k] = 0;
        if (abort) begin
            m_phase[k] = P_IDLE; m_base[k] = 0; m_act[k] = 0;
        end else if (load && m_phase[k] != P_RUN) begin
            m_phase[k] = P_LOADED; m_base[k] = int'(start); m_rel[k] = int'(start); m_act[k] = 0;
        end else if (run) begin
            if (m_phase[k] == P_LOADED) begin
                m_phase[k] = P_RUN; m_act[k] = 0;
            end else if (m_phase[k] == P_RUN) begin
                if (m_base[k] != 0) m_act[k]++;
                if (m_base[k] == 0 || m_act[k] == m_base[k] * td[k]) begin
                    m_phase[k] = P_DONE; m_pulse[k] = 1;
                end
            end else if (m_phase[k] == P_DONE && AUTO) begin
                m_phase[k] = P_RUN; m_base[k] = m_rel[k]; m_act[k] = 0;
            end
        end
    endfunction

    function automatic int exp_count(int k);
        if (m_phase[k] == P_LOADED) return m_base[k];
        if (m_phase[k] == P_RUN) return m_base[k] - m_act[k] / td[k];
        return 0;
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_reset(0); m_reset(1);
        end else begin
            m_step(0); m_step(1);
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("count1", int'(count1), exp_count(0));
            chk("busy1", int'(busy1), int'(m_phase[0] == P_RUN));
            chk("done1", int'(done1), int'(m_phase[0] == P_DONE));
            chk("pulse1", int'(dp1), m_pulse[0]);
            chk("count4", int'(count4), exp_count(1));
            chk("busy4", int'(busy4), int'(m_phase[1] == P_RUN));
            chk("done4", int'(done4), int'(m_phase[1] == P_DONE));
            chk("pulse4", int'(dp4), m_pulse[1]);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic fresh_load(input int v);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        start = W'(v);
        load  = 1'b1;
        @(negedge clock);
        load  = 1'b0;
    endtask

    initial begin
        int cycles;
        int pulses;

        repeat (2) @(negedge clock);
        chk("rst_count", int'(count1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_done", int'(done1), 0);
        chk("rst_pulse", int'(dp1), 0);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        @(negedge clock);

        // Basic count, TICK_DIV=1
        fresh_load(5);
        chk("t1_loaded", int'(count1), 5);
        run = 1'b1;
        @(negedge clock);
        chk("t1_busy", int'(busy1), 1);
        chk("t1_entry", int'(count1), 5);
        cycles = 0;
        while (!done1 && cycles < 50) begin
            @(negedge clock);
            cycles++;
            if (!done1) chk("t1_count", int'(count1), 5 - cycles);
        end
        chk("t1_latency", cycles, 5);
        chk("t1_zero", int'(count1), 0);
        chk("t1_pulse", int'(dp1), 1);
        run = 1'b0;
        @(negedge clock);
        chk("t1_pulse_end", int'(dp1), 0);
        chk("t1_done_hold", int'(done1), 1);

        // Prescaled count, TICK_DIV=4
        fresh_load(3);
        run = 1'b1;
        @(negedge clock);
        chk("t2_entry", int'(count4), 3);
        cycles = 0;
        while (!done4 && cycles < 100) begin
            @(negedge clock);
            cycles++;
            if (cycles == 3) chk("t2_before_tick", int'(count4), 3);
            if (cycles == 4) chk("t2_first_tick", int'(count4), 2);
        end
        chk("t2_latency", cycles, 12);
        run = 1'b0;
        @(negedge clock);

        // Zero start
        fresh_load(0);
        run = 1'b1;
        @(negedge clock);
        chk("t3_busy", int'(busy1), 1);
        chk("t3_count", int'(count1), 0);
        @(negedge clock);
        chk("t3_done", int'(done1), 1);
        chk("t3_pulse", int'(dp1), 1);
        run = 1'b0;
        @(negedge clock);
        chk("t3_pulse_end", int'(dp1), 0);
        chk("t3_done_hold", int'(done1), 1);

        // Pause mid-count, TICK_DIV=4
        fresh_load(10);
        run = 1'b1;
        @(negedge clock);
        cycles = 0;
        repeat (15) begin @(negedge clock); cycles++; end
        chk("t4_before_pause", int'(count4), 7);
        run = 1'b0;
        repeat (7) begin
            @(negedge clock);
            cycles++;
            chk("t4_frozen", int'(count4), 7);
            chk("t4_busy", int'(busy4), 1);
        end
        run = 1'b1;
        while (!done4 && cycles < 200) begin @(negedge clock); cycles++; end
        chk("t4_latency", cycles, 47);

        // Abort, asynchronous reset, load+abort
        fresh_load(511);
        run = 1'b1;
        @(negedge clock);
        repeat (311) @(negedge clock);
        chk("t5_at200", int'(count1), 200);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("t5_abort_count", int'(count1), 0);
        chk("t5_abort_busy", int'(busy1), 0);
        chk("t5_abort_done", int'(done1), 0);
        fresh_load(511);
        @(negedge clock);
        repeat (311) @(negedge clock);
        chk("t5_at200b", int'(count1), 200);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_count", int'(count1), 0);
        chk("t5_rst_busy", int'(busy1), 0);
        chk("t5_rst_done", int'(done1), 0);
        chk("t5_rst_pulse", int'(dp1), 0);
        chk("t5_rst_count4", int'(count4), 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("t5_needs_load", int'(count1), 0);
        chk("t5_needs_load_busy", int'(busy1), 0);
        start = W'(9);
        load  = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        load  = 1'b0;
        abort = 1'b0;
        chk("t5_load_abort", int'(count1), 0);
        chk("t5_load_abort_busy", int'(busy1), 0);

        // Periodic versus single done_pulse
        fresh_load(2);
        run = 1'b1;
        @(negedge clock);
        pulses = 0;
        repeat (20) begin
            @(negedge clock);
            if (dp1) pulses++;
        end
        chk("t6_pulses", pulses, AUTO ? 7 : 1);
        run = 1'b0;
        @(negedge clock);

        // Randomized traffic checked by the model
        repeat (3000) begin
            abort = ($urandom_range(0, 99) < 2);
            load  = ($urandom_range(0, 99) < 8);
            run   = ($urandom_range(0, 99) < 85);
            start = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 12));
            if ($urandom_range(0, 499) == 0) begin
                #1 reset_n = 1'b0;
                #2 reset_n = 1'b1;
            end
            @(negedge clock);
        end

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_down_timer.md
COUNT_DOWN_TIMER -- requirements
Module: count_down_timer

Interface
REQ-001 Parameter WIDTH, default 9: width of the start value and count.
REQ-002 Parameter TICK_DIV, default 1: clock cycles per decrement.
REQ-003 Port clock  input  1: single clock; all state changes on its rising edge.
REQ-004 Port reset_n  input  1: reset, asynchronous and active-low.
REQ-005 Port start  input  WIDTH: value to count down from; sampled only when load is high.
REQ-006 Port load  input  1: load request; captures start and enters LOADED.
REQ-007 Port run  input  1: level enable; high counts, low pauses.
REQ-008 Port abort  input  1: cancel; forces IDLE from any state.
REQ-009 Port count  output  WIDTH: current remaining count, registered.
REQ-010 Port busy  output  1: high exactly while the state is RUNNING.
REQ-011 Port done  output  1: high exactly while the state is DONE.
REQ-012 Port done_pulse  output  1: single-cycle pulse on the edge entering DONE.

Function
REQ-013 The block SHALL implement the states IDLE, LOADED, RUNNING and DONE, with all outputs decoded from registers.
REQ-014 Input priority SHALL be abort > load > run in every state.
REQ-015 abort SHALL force IDLE, count=0 and prescaler=0 on the next edge.
REQ-016 load in IDLE, LOADED or DONE SHALL do all of the following on the next edge:
- capture start into count and into a stored reload register;
- clear the prescaler;
- enter LOADED.
REQ-017 load in RUNNING SHALL be ignored.
REQ-018 In LOADED, run=1 SHALL enter RUNNING on the next edge with the prescaler cleared; run=0 SHALL hold in LOADED.
REQ-019 In RUNNING with run=1, the prescaler SHALL increment each cycle. On reaching TICK_DIV-1 it SHALL produce a tick, clear itself and decrement count.
REQ-020 The tick that takes count from 1 to 0 SHALL also enter DONE on the same edge and assert done_pulse for that one cycle.
REQ-021 If RUNNING is entered with count=0, the block SHALL enter DONE on the next edge with no decrement.
REQ-022 Latency: for start=N≥1, done SHALL rise exactly N*TICK_DIV cycles after the edge that enters RUNNING.
REQ-023 In RUNNING with run=0, count and prescaler SHALL hold; busy SHALL stay 1; resuming SHALL continue from the held prescaler value.
REQ-024 count SHALL never wrap below 0.
REQ-025 The arithmetic width rules SHALL be:
- count and reload are WIDTH bits;
- the prescaler is clog2(TICK_DIV) bits, with a minimum of 1.
REQ-026 In DONE, count SHALL hold 0 and the block SHALL stay in DONE until load, abort or the REQ-031 condition.
REQ-027 load and abort in the same cycle SHALL resolve to IDLE.

Reset
REQ-028 reset_n low SHALL immediately, without a clock edge, set:
- state=IDLE;
- count=0, prescaler=0, reload register=0;
- busy=0, done=0, done_pulse=0.
REQ-029 Reset asserted mid-count SHALL discard all progress. After release, the block SHALL require a new load.
REQ-030 reset_n release SHALL be synchronised externally. The block SHALL take no action on the release edge beyond normal IDLE behaviour.

Configuration
REQ-031 With macro COUNT_DOWN_TIMER_AUTO_RELOAD_EN defined, DONE with run=1 and no load or abort SHALL do the following on the next edge:
- reload count from the reload register;
- clear the prescaler;
- re-enter RUNNING;
- produce a periodic done_pulse every reload*TICK_DIV+1 cycles.
REQ-032 Without COUNT_DOWN_TIMER_AUTO_RELOAD_EN, DONE SHALL ignore run, and the reload register SHALL be permitted to be optimised away.

Verification
REQ-033 WIDTH=9, TICK_DIV=1, start=5, load, then run=1 -> count 5,4,3,2,1,0; done rises 5 cycles after RUNNING entry; done_pulse high 1 cycle.
REQ-034 TICK_DIV=4, start=3, run=1 -> count decrements every 4th cycle; done at cycle 12 after RUNNING entry.
REQ-035 start=0, load, run=1 -> DONE one cycle after RUNNING entry; count stays 0; done_pulse once.
REQ-036 TICK_DIV=4, start=10, run low for 7 cycles mid-count -> count and prescaler frozen, busy=1; total done latency = 40+7 cycles.
REQ-037 start=511, abort or reset_n low at count=200 -> IDLE, count=0 and outputs 0 (reset takes effect without a clock edge); load+abort together -> IDLE.
REQ-038 With COUNT_DOWN_TIMER_AUTO_RELOAD_EN, start=2, TICK_DIV=1, run held high -> done_pulse every 3 cycles; without the macro -> a single done_pulse, then done held.
